// File: rtl/chnl_dump_if.sv
// -----------------------------------------------------------------------------
// chnl_dump_if
//   Groups every signal between the channel dump controller and its neighbours:
//   the command processor, the capture RAM read port and the UART transmitter.
//
//   Handshake rules (one place, all of them):
//     dump_req / dump_chnl / start_addr : dump_req is a 1-cycle pulse; channel
//       and address are sampled only in the cycle dump_req is accepted.
//       Acceptance shows up as dump_busy the following cycle; a rejected
//       request shows up as a 1-cycle dump_err instead.
//     ram_en / ram_addr / ram_sel -> ram_rdata : synchronous read; ram_rdata
//       is valid in the cycle after ram_en was high.
//     trmt -> tx_done : trmt is a 1-cycle pulse that hands tx_data to the
//       UART; tx_data stays stable until tx_done is returned. tx_done is only
//       honoured while a byte is outstanding.
//     dump_done : 1-cycle pulse after the last byte's tx_done.
//
//   Modports:
//     master : the dump controller (drives RAM read port, UART and status)
//     slave  : the environment (command processor, RAMs, UART)
// -----------------------------------------------------------------------------
interface chnl_dump_if #(
  parameter int ADDR_W = 9
);
  logic              dump_req;
  logic [2:0]        dump_chnl;
  logic [ADDR_W-1:0] start_addr;

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        ram_sel;
  logic [7:0]        ram_rdata;

  logic [7:0]        tx_data;
  logic              trmt;
  logic              tx_done;

  logic              dump_busy;
  logic              dump_done;
  logic              dump_err;

  modport master (
    input  dump_req, dump_chnl, start_addr, ram_rdata, tx_done,
    output ram_en, ram_addr, ram_sel, tx_data, trmt,
           dump_busy, dump_done, dump_err
  );

  modport slave (
    output dump_req, dump_chnl, start_addr, ram_rdata, tx_done,
    input  ram_en, ram_addr, ram_sel, tx_data, trmt,
           dump_busy, dump_done, dump_err
  );
endinterface

// File: rtl/chnl_dump_ctrl.sv
// -----------------------------------------------------------------------------
// chnl_dump_ctrl
//   Sequences a logic-analyzer channel dump. On an accepted dump request it
//   reads the selected channel's circular capture RAM starting at the oldest
//   sample, wraps once at ENTRIES-1 -> 0, and hands each byte to the UART
//   transmitter with a trmt/tx_done handshake. Exactly ENTRIES bytes are sent.
//
//   Parameters:
//     ENTRIES : capture RAM depth in bytes per channel
//     ADDR_W  : RAM address width, 2**ADDR_W must be >= ENTRIES
//
//   Ports:
//     clk       : system clock
//     rst       : asynchronous reset, active-high
//     bus       : chnl_dump_if.master (request, RAM read port, UART, status)
//     dbg_state : current FSM state encoding (IDLE=0 RD=1 LATCH=2 SEND=3
//                 WAIT=4 DONE=5)
//
//   Timing per byte: RD (ram_en high), LATCH (RAM data captured into tx_data),
//   SEND (trmt high), then WAIT until tx_done. With the request cycle counted
//   as the first, ram_en is high in the second cycle.
// -----------------------------------------------------------------------------
module chnl_dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int ADDR_W  = 9
) (
  input  logic       clk,
  input  logic       rst,
  chnl_dump_if.master bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    LATCH = 3'd2,
    SEND  = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // One extra bit so that a count equal to ENTRIES is representable.
  localparam logic [ADDR_W:0]   ENTRIES_W = (ADDR_W+1)'(ENTRIES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] start_eff;
  logic              chnl_ok;

  assign dbg_state = state;

  // Only channels 1..5 exist; 0, 6 and 7 are rejected with dump_err.
  assign chnl_ok = (bus.dump_chnl != 3'd0) && (bus.dump_chnl <= 3'd5);

  // A write pointer beyond the RAM depth cannot be a real oldest sample;
  // start from 0 rather than reading unused addresses.
  assign start_eff = ({1'b0, bus.start_addr} >= ENTRIES_W) ? '0 : bus.start_addr;

  assign count_next = count + (ADDR_W+1)'(1);

  // Circular increment that never enters addresses >= ENTRIES.
  assign addr_next = (bus.ram_addr == LAST_ADDR) ? '0 : bus.ram_addr + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      bus.ram_en    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_sel   <= 3'd0;
      bus.tx_data   <= 8'd0;
      bus.trmt      <= 1'b0;
      bus.dump_busy <= 1'b0;
      bus.dump_done <= 1'b0;
      bus.dump_err  <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle on
      // the transition into the state that owns it.
      bus.ram_en    <= 1'b0;
      bus.trmt      <= 1'b0;
      bus.dump_done <= 1'b0;
      bus.dump_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.dump_req) begin
            if (chnl_ok) begin
              bus.ram_sel   <= bus.dump_chnl;
              bus.ram_addr  <= start_eff;
              count         <= '0;
              bus.dump_busy <= 1'b1;
              bus.ram_en    <= 1'b1;
              state         <= RD;
            end else begin
              bus.dump_err <= 1'b1;
            end
          end
        end

        // ram_en is high during this cycle; the RAM returns data next cycle.
        RD: begin
          state <= LATCH;
        end

        // RAM data is valid now; capture it and start the UART in SEND.
        LATCH: begin
          bus.tx_data <= bus.ram_rdata;
          bus.trmt    <= 1'b1;
          state       <= SEND;
        end

        SEND: begin
          state <= WAIT;
        end

        // tx_data is not touched here, so it stays stable for the UART.
        WAIT: begin
          if (bus.tx_done) begin
            count <= count_next;
            if (count_next == ENTRIES_W) begin
              bus.dump_done <= 1'b1;
              bus.dump_busy <= 1'b0;
              state         <= DONE;
            end else begin
              bus.ram_addr <= addr_next;
              bus.ram_en   <= 1'b1;
              state        <= RD;
            end
          end
        end

        // dump_done is high here; requests are not looked at until IDLE.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chnl_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_chnl_dump_ctrl
//   Self-checking bench for chnl_dump_ctrl: a synchronous RAM model, a UART
//   model with programmable tx_done delay, a negedge monitor and a byte
//   scoreboard fed when each dump request is driven.
// -----------------------------------------------------------------------------
module tb_chnl_dump_ctrl;

  localparam int ENTRIES = 384;
  localparam int ADDR_W  = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chnl_dump_if #(.ADDR_W(ADDR_W)) bus ();
  logic [2:0] dbg_state;

  chnl_dump_ctrl #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mem [0:7][0:511];
  logic [2:0] exp_sel;

  // written only by the monitor
  int         bytes_seen  = 0;
  int         done_cnt    = 0;
  int         err_cnt     = 0;
  int         ram_en_cnt  = 0;
  int         trmt_cnt    = 0;
  int         busy_cycles = 0;
  bit         outstanding = 1'b0;
  logic [7:0] held_byte   = 8'd0;

  // written only by the main sequence
  int tx_delay   = 1;
  bit stray_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- RAM model: data valid the cycle after ram_en ----------------
  initial begin : ram_model
    logic              rd_pend;
    logic [ADDR_W-1:0] rd_a;
    logic [2:0]        rd_s;
    bus.ram_rdata = 8'd0;
    forever begin
      @(negedge clk);
      rd_pend = bus.ram_en;
      rd_a    = bus.ram_addr;
      rd_s    = bus.ram_sel;
      @(posedge clk);
      #1;
      if (rd_pend) bus.ram_rdata = mem[rd_s][rd_a];
    end
  end

  // ---------------- UART model ----------------
  initial begin : uart_model
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.trmt) begin
        repeat (tx_delay - 1) @(posedge clk);
        @(posedge clk); #1 bus.tx_done = 1'b1;
        @(posedge clk); #1 bus.tx_done = 1'b0;
      end else if (stray_mode) begin
        @(posedge clk); #1 bus.tx_done = 1'b1;
        @(posedge clk); #1 bus.tx_done = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        if (bus.ram_en) begin
          ram_en_cnt++;
          check("ram_addr_range", 32'(32'(bus.ram_addr) < ENTRIES), 32'd1);
          check("ram_sel", 32'(bus.ram_sel), 32'(exp_sel));
        end
        if (bus.tx_done && outstanding) begin
          check("tx_data_stable", 32'(bus.tx_data), 32'(held_byte));
          outstanding = 1'b0;
        end
        if (bus.trmt) begin
          trmt_cnt++;
          check("no_extra_trmt", 32'(outstanding), 32'd0);
          if (exp_q.size() == 0) check("byte_expected", 32'(exp_q.size()), 32'd1);
          else check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          held_byte   = bus.tx_data;
          outstanding = 1'b1;
          bytes_seen++;
        end
        if (bus.dump_done) done_cnt++;
        if (bus.dump_err)  err_cnt++;
        if (bus.dump_busy) busy_cycles++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_dump(input logic [2:0] ch, input logic [ADDR_W-1:0] sa);
    int base;
    base = (32'(sa) >= ENTRIES) ? 0 : 32'(sa);
    for (int k = 0; k < ENTRIES; k++) exp_q.push_back(mem[ch][(base + k) % ENTRIES]);
    exp_sel = ch;
    @(posedge clk); #1;
    bus.dump_req   = 1'b1;
    bus.dump_chnl  = ch;
    bus.start_addr = sa;
    @(posedge clk); #1;
    bus.dump_req   = 1'b0;
    // scramble sampled-once inputs; the dump in progress must not notice
    bus.dump_chnl  = 3'($urandom_range(0, 7));
    bus.start_addr = ADDR_W'($urandom_range(0, 511));
    @(negedge clk);
    check("first_ram_en", 32'(bus.ram_en), 32'd1);
    check("busy_after_req", 32'(bus.dump_busy), 32'd1);
    check("first_addr", 32'(bus.ram_addr), 32'(base));
  endtask

  task automatic wait_done(input int start_done, input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == start_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(tag, 32'(done_cnt - start_done), 32'd1);
    check("idle_after_done", 32'(dbg_state), 32'd0);
    check("busy_after_done", 32'(bus.dump_busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (bytes_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bytes_seen >= target), 32'd1);
  endtask

  task automatic bad_req(input logic [2:0] ch);
    int e0, r0, t0, b0;
    e0 = err_cnt; r0 = ram_en_cnt; t0 = trmt_cnt; b0 = busy_cycles;
    @(posedge clk); #1;
    bus.dump_req  = 1'b1;
    bus.dump_chnl = ch;
    @(posedge clk); #1;
    bus.dump_req  = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(bus.dump_err), 32'd1);
    check("err_busy", 32'(bus.dump_busy), 32'd0);
    check("err_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(bus.dump_err), 32'd0);
    repeat (4) @(negedge clk);
    check("err_count", 32'(err_cnt - e0), 32'd1);
    check("err_no_ram", 32'(ram_en_cnt - r0), 32'd0);
    check("err_no_trmt", 32'(trmt_cnt - t0), 32'd0);
    check("err_no_busy", 32'(busy_cycles - b0), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main_seq
    int b0, d0, e0, r0, t0, c0;
    rst            = 1'b1;
    bus.dump_req   = 1'b0;
    bus.dump_chnl  = 3'd0;
    bus.start_addr = '0;
    exp_sel        = 3'd0;
    for (int ch = 0; ch < 8; ch++)
      for (int a = 0; a < 512; a++)
        mem[ch][a] = (ch == 1) ? 8'(a) : 8'($urandom_range(0, 255));

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_en", 32'(bus.ram_en), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_sel", 32'(bus.ram_sel), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_trmt", 32'(bus.trmt), 32'd0);
    check("rst_busy", 32'(bus.dump_busy), 32'd0);
    check("rst_done", 32'(bus.dump_done), 32'd0);
    check("rst_err", 32'(bus.dump_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: channel 1 from address 0, bytes 00..FF then 00..7F
    b0 = bytes_seen; d0 = done_cnt;
    do_dump(3'd1, 9'd0);
    wait_done(d0, 5000, "t1_done");
    check("t1_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));

    // 2: channel 3 starting at the last address, wraps to 0
    b0 = bytes_seen; d0 = done_cnt;
    do_dump(3'd3, 9'd383);
    wait_done(d0, 5000, "t2_done");
    check("t2_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));

    // start address beyond the RAM depth starts from 0
    b0 = bytes_seen; d0 = done_cnt;
    do_dump(3'd4, 9'd500);
    wait_done(d0, 5000, "oob_done");
    check("oob_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));

    // 3: invalid channels
    bad_req(3'd0);
    bad_req(3'd6);
    bad_req(3'd7);

    // 4: second request during a dump is ignored
    b0 = bytes_seen; d0 = done_cnt; e0 = err_cnt;
    do_dump(3'd5, ADDR_W'($urandom_range(0, 383)));
    wait_bytes(b0 + 10, 200, "t4_reach_10");
    @(posedge clk); #1;
    bus.dump_req   = 1'b1;
    bus.dump_chnl  = 3'd2;
    bus.start_addr = 9'd7;
    @(posedge clk); #1;
    bus.dump_req   = 1'b0;
    wait_done(d0, 5000, "t4_done");
    check("t4_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));
    check("t4_no_err", 32'(err_cnt - e0), 32'd0);

    // 5: reset in the middle of a dump
    b0 = bytes_seen; d0 = done_cnt; e0 = err_cnt;
    do_dump(3'd2, 9'd50);
    wait_bytes(b0 + 100, 1000, "t5_reach_100");
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ram_en", 32'(bus.ram_en), 32'd0);
    check("t5_rst_trmt", 32'(bus.trmt), 32'd0);
    check("t5_rst_busy", 32'(bus.dump_busy), 32'd0);
    check("t5_rst_addr", 32'(bus.ram_addr), 32'd0);
    check("t5_rst_sel", 32'(bus.ram_sel), 32'd0);
    check("t5_rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("t5_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_no_err", 32'(err_cnt - e0), 32'd0);
    b0 = bytes_seen;
    do_dump(3'd2, 9'd50);
    wait_done(d0, 5000, "t5_fresh_done");
    check("t5_fresh_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));

    // 6: slow UART on the first bytes, then normal
    b0 = bytes_seen; d0 = done_cnt;
    tx_delay = 1000;
    do_dump(3'd1, 9'd200);
    wait_bytes(b0 + 3, 5000, "t6_slow_bytes");
    tx_delay = 1;
    wait_done(d0, 8000, "t6_done");
    check("t6_bytes", 32'(bytes_seen - b0), 32'(ENTRIES));

    // stray tx_done pulses while idle
    r0 = ram_en_cnt; t0 = trmt_cnt; c0 = busy_cycles; d0 = done_cnt; e0 = err_cnt;
    stray_mode = 1'b1;
    repeat (40) @(negedge clk);
    stray_mode = 1'b0;
    repeat (4) @(negedge clk);
    check("stray_no_ram", 32'(ram_en_cnt - r0), 32'd0);
    check("stray_no_trmt", 32'(trmt_cnt - t0), 32'd0);
    check("stray_no_busy", 32'(busy_cycles - c0), 32'd0);
    check("stray_no_done", 32'(done_cnt - d0), 32'd0);
    check("stray_no_err", 32'(err_cnt - e0), 32'd0);
    check("stray_state", 32'(dbg_state), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

endmodule
